// File: rtl/led_tape_pkg.sv
// Shared types and helpers for the LED tape frame scheduler.
// Latency: none (types, constants and a combinational function).
// Backpressure: not applicable.
package led_tape_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef logic [1:0] grant_t;

    localparam grant_t GRANT_NONE = 2'b00;
    localparam grant_t GRANT_SRC0 = 2'b01;
    localparam grant_t GRANT_SRC1 = 2'b10;

    // (c * (b + 1)) >> 8: b = FF is identity, b = 00 gives 0.
    // The product tops out at 255 * 256, so 16 bits are enough.
    function automatic logic [7:0] scale8(input logic [7:0] c, input logic [7:0] b);
        logic [15:0] prod;
        prod = {8'd0, c} * ({8'd0, b} + 16'd1);
        return prod[15:8];
    endfunction

endpackage

// File: rtl/led_sched_arb.sv
// Frame-boundary detector with a round-robin grant register and frame counter.
// Latency: grant and frame_start change on the edge after tape_sync's rise is registered.
// Backpressure: none; src_req is a level sampled only at frame boundaries.
module led_sched_arb
    import led_tape_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tape_sync,
    input  logic [1:0]  src_req,
    output grant_t      src_grant,
    output logic        frame_start,
    output logic [15:0] frame_cnt
);

    logic [1:0] r_sync;
    logic       boundary;
    logic       last;
    logic       last_nxt;
    grant_t     grant_nxt;

    // Sync history, bit 0 is the newest sample; 01 marks a rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], tape_sync};
        end
    end

    assign boundary = (r_sync == 2'b01);

    // Round-robin choice; evaluated every cycle but only applied on a boundary.
    // 'last' names the source granted most recently and survives idle frames.
    always_comb begin
        grant_nxt = GRANT_NONE;
        last_nxt  = last;
        case (src_req)
            2'b11: begin
                if (last) begin
                    grant_nxt = GRANT_SRC0;
                    last_nxt  = 1'b0;
                end else begin
                    grant_nxt = GRANT_SRC1;
                    last_nxt  = 1'b1;
                end
            end
            2'b01: begin
                grant_nxt = GRANT_SRC0;
                last_nxt  = 1'b0;
            end
            2'b10: begin
                grant_nxt = GRANT_SRC1;
                last_nxt  = 1'b1;
            end
            default: begin
                grant_nxt = GRANT_NONE;
                last_nxt  = last;
            end
        endcase
    end

    // Grant, pointer and counter move only at a boundary; frame_start marks it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_grant   <= GRANT_NONE;
            last        <= 1'b1;
            frame_start <= 1'b0;
            frame_cnt   <= 16'd0;
        end else begin
            frame_start <= boundary;
            if (boundary) begin
                src_grant <= grant_nxt;
                last      <= last_nxt;
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/led_tape_sched.sv
// Frame scheduler sharing one LED tape between two pixel sources (brightness: LED_SCHED_BRIGHTNESS_EN).
// Latency: tape_req at edge k -> src_rd after k, tape_rgb after k+2; one request per cycle.
// Backpressure: none; sources must answer exactly one cycle after src_rd.
module led_tape_sched
    import led_tape_pkg::*;
#(
    parameter int NUM_LEDS = 7,
    parameter int ADDR_W   = 16
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tape_req,
    input  logic [15:0]       tape_num,
    input  logic              tape_sync,
    output logic [23:0]       tape_rgb,
    input  logic [1:0]        src_req,
    output grant_t            src_grant,
    output logic              src_rd,
    output logic [ADDR_W-1:0] src_addr,
    input  logic [23:0]       src_rgb0,
    input  logic [23:0]       src_rgb1,
    output logic              frame_start,
`ifdef LED_SCHED_BRIGHTNESS_EN
    input  logic [7:0]        brightness,
`endif
    output logic [15:0]       frame_cnt
);

    // The address bus must be able to name every LED of a frame.
    if (ADDR_W < $clog2(NUM_LEDS)) begin : g_addr_w_check
        $error("ADDR_W too narrow for NUM_LEDS");
    end

    grant_t sel1;
    grant_t sel2;
    logic   vld2;
    rgb_t   pix;
    rgb_t   pix_out;

    led_sched_arb u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .tape_sync   (tape_sync),
        .src_req     (src_req),
        .src_grant   (src_grant),
        .frame_start (frame_start),
        .frame_cnt   (frame_cnt)
    );

    // S0: issue the read; sel takes the grant as it stands before any boundary update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_rd   <= 1'b0;
            src_addr <= '0;
            sel1     <= GRANT_NONE;
        end else begin
            src_rd <= tape_req;
            if (tape_req) begin
                src_addr <= tape_num[ADDR_W-1:0];
                sel1     <= src_grant;
            end
        end
    end

    // S1: the source drives its data while the selector and valid advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld2 <= 1'b0;
            sel2 <= GRANT_NONE;
        end else begin
            vld2 <= src_rd;
            sel2 <= sel1;
        end
    end

    // Source select; a frame without an owner reads as black.
    always_comb begin
        pix = '0;
        if (sel2[0]) begin
            pix = src_rgb0;
        end else if (sel2[1]) begin
            pix = src_rgb1;
        end
    end

`ifdef LED_SCHED_BRIGHTNESS_EN
    // Per-channel global brightness scaling inside S2.
    always_comb begin
        pix_out   = '0;
        pix_out.r = scale8(pix.r, brightness);
        pix_out.g = scale8(pix.g, brightness);
        pix_out.b = scale8(pix.b, brightness);
    end
`else
    assign pix_out = pix;
`endif

    // S2: register the colour onto the tape; hold it between requests.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tape_rgb <= 24'h0;
        end else if (vld2) begin
            tape_rgb <= pix_out;
        end
    end

endmodule

// File: tb/tb_led_tape_sched.sv
// Directed bench for led_tape_sched with a colour scoreboard and a one-cycle-latency source model.
// Latency: expected tape_rgb is due three negedges after the negedge that drives tape_req.
// Backpressure: none; the source model answers every read.
module tb_led_tape_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tape_req;
    logic [15:0] tape_num;
    logic        tape_sync;
    logic [23:0] tape_rgb;
    logic [1:0]  src_req;
    logic [1:0]  src_grant;
    logic        src_rd;
    logic [15:0] src_addr;
    logic [23:0] src_rgb0;
    logic [23:0] src_rgb1;
    logic        frame_start;
    logic [15:0] frame_cnt;
`ifdef LED_SCHED_BRIGHTNESS_EN
    logic [7:0]  brightness;
`endif

    always #5 clk = ~clk;

    led_tape_sched #(.NUM_LEDS(7), .ADDR_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tape_req    (tape_req),
        .tape_num    (tape_num),
        .tape_sync   (tape_sync),
        .tape_rgb    (tape_rgb),
        .src_req     (src_req),
        .src_grant   (src_grant),
        .src_rd      (src_rd),
        .src_addr    (src_addr),
        .src_rgb0    (src_rgb0),
        .src_rgb1    (src_rgb1),
        .frame_start (frame_start),
`ifdef LED_SCHED_BRIGHTNESS_EN
        .brightness  (brightness),
`endif
        .frame_cnt   (frame_cnt)
    );

    typedef struct {
        int          due;
        logic [23:0] val;
    } sb_t;

    sb_t         sb[$];
    logic [23:0] mem0 [16];
    logic [23:0] mem1 [16];
    int          cyc = 0;
    int          checks = 0;
    int          passed = 0;
    logic [15:0] exp_cnt;
    logic [1:0]  cur_g;

    always @(posedge clk) cyc <= cyc + 1;

    // Source model: data one cycle after src_rd, garbage otherwise.
    always @(posedge clk) begin
        if (src_rd === 1'b1) begin
            src_rgb0 <= mem0[src_addr[3:0]];
            src_rgb1 <= mem1[src_addr[3:0]];
        end else begin
            src_rgb0 <= 24'hDEAD00;
            src_rgb1 <= 24'hBEEF00;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] expv(input logic [1:0] g, input logic [15:0] a);
        if (g == 2'b01) return mem0[a[3:0]];
        if (g == 2'b10) return mem1[a[3:0]];
        return 24'h0;
    endfunction

    // Scoreboard consumer: compare each colour on the negedge it falls due.
    always @(negedge clk) begin
        sb_t e;
        if (sb.size() != 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            chk("tape_rgb", 32'(tape_rgb), 32'(e.val));
        end
    end

    task automatic push(input logic [23:0] v);
        sb_t e;
        e.due = cyc + 3;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic send(input logic [15:0] a, input logic [23:0] v);
        tape_req = 1'b1;
        tape_num = a;
        push(v);
        @(negedge clk);
        tape_req = 1'b0;
        chk("src_rd_hi", 32'(src_rd), 1);
        chk("src_addr", 32'(src_addr), 32'(a));
        @(negedge clk);
        chk("src_rd_lo", 32'(src_rd), 0);
    endtask

    task automatic boundary(input logic [1:0] g);
        tape_sync = 1'b1;
        @(negedge clk);
        chk("fs_early", 32'(frame_start), 0);
        @(negedge clk);
        exp_cnt = exp_cnt + 16'd1;
        chk("fs_pulse", 32'(frame_start), 1);
        chk("grant", 32'(src_grant), 32'(g));
        chk("frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
        @(negedge clk);
        chk("fs_end", 32'(frame_start), 0);
        tape_sync = 1'b0;
        cur_g = g;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem0[i] = {8'hA0 + 8'(i), 8'(i * 17), 8'h5C};
            mem1[i] = {8'h0F, 8'h30 + 8'(i), 8'hC0 - 8'(i)};
        end
        rst_n     = 1'b0;
        tape_req  = 1'b0;
        tape_num  = 16'd0;
        tape_sync = 1'b0;
        src_req   = 2'b00;
        exp_cnt   = 16'd0;
        cur_g     = 2'b00;
`ifdef LED_SCHED_BRIGHTNESS_EN
        brightness = 8'hFF;
`endif
        repeat (3) @(negedge clk);
        chk("rst_rgb", 32'(tape_rgb), 0);
        chk("rst_grant", 32'(src_grant), 0);
        chk("rst_rd", 32'(src_rd), 0);
        chk("rst_addr", 32'(src_addr), 0);
        chk("rst_fs", 32'(frame_start), 0);
        chk("rst_cnt", 32'(frame_cnt), 0);
        rst_n   = 1'b1;
        src_req = 2'b01;
        @(negedge clk);

        // Blank frame before the first boundary.
        send(16'd0, 24'h0);
        send(16'd1, 24'h0);

        // Single requester, full 7-LED frame from source 0.
        boundary(2'b01);
        for (int i = 0; i < 7; i++) send(16'(i), expv(cur_g, 16'(i)));

        // Both requesting: alternate, source 0 was granted last.
        src_req = 2'b11;
        boundary(2'b10);
        send(16'd2, expv(cur_g, 16'd2));
        boundary(2'b01);
        send(16'd3, expv(cur_g, 16'd3));
        boundary(2'b10);
        send(16'd4, expv(cur_g, 16'd4));
        boundary(2'b01);
        send(16'd5, expv(cur_g, 16'd5));

        // Request dropped mid-frame: grant holds, next frame blank.
        src_req = 2'b10;
        boundary(2'b10);
        send(16'd1, expv(cur_g, 16'd1));
        src_req = 2'b00;
        send(16'd2, expv(cur_g, 16'd2));
        chk("grant_hold", 32'(src_grant), 2);
        send(16'd3, expv(cur_g, 16'd3));
        boundary(2'b00);
        for (int i = 0; i < 7; i++) send(16'(i), 24'h0);

        // Back-to-back requests for 3 and 4.
        src_req = 2'b01;
        boundary(2'b01);
        tape_req = 1'b1;
        tape_num = 16'd3;
        push(expv(cur_g, 16'd3));
        @(negedge clk);
        tape_num = 16'd4;
        push(expv(cur_g, 16'd4));
        chk("b2b_rd0", 32'(src_rd), 1);
        chk("b2b_addr0", 32'(src_addr), 3);
        @(negedge clk);
        tape_req = 1'b0;
        chk("b2b_rd1", 32'(src_rd), 1);
        chk("b2b_addr1", 32'(src_addr), 4);
        @(negedge clk);
        chk("b2b_rd_lo", 32'(src_rd), 0);
        repeat (3) @(negedge clk);
        chk("rgb_hold", 32'(tape_rgb), 32'(mem0[4]));

        // Indices beyond the frame are forwarded without a range check.
        send(16'd9, expv(cur_g, 16'd9));
        send(16'h1234, expv(cur_g, 16'h1234));

        // Boundary and request on the same edge: the read uses the old grant.
        src_req = 2'b10;
        tape_sync = 1'b1;
        @(negedge clk);
        tape_req = 1'b1;
        tape_num = 16'd5;
        push(expv(cur_g, 16'd5));
        @(negedge clk);
        tape_req = 1'b0;
        exp_cnt = exp_cnt + 16'd1;
        chk("sim_fs", 32'(frame_start), 1);
        chk("sim_grant", 32'(src_grant), 2);
        chk("sim_rd", 32'(src_rd), 1);
        chk("sim_cnt", 32'(frame_cnt), 32'(exp_cnt));
        @(negedge clk);
        tape_sync = 1'b0;
        cur_g = 2'b10;
        send(16'd6, expv(cur_g, 16'd6));

        // Frame counter wrap.
        force dut.u_arb.frame_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.u_arb.frame_cnt;
        exp_cnt = 16'hFFFF;
        @(negedge clk);
        src_req = 2'b01;
        boundary(2'b01);
        send(16'd2, expv(cur_g, 16'd2));

        // Reset mid-frame with a read in flight.
        tape_req = 1'b1;
        tape_num = 16'd2;
        @(negedge clk);
        tape_req = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mrst_rgb", 32'(tape_rgb), 0);
        chk("mrst_grant", 32'(src_grant), 0);
        chk("mrst_rd", 32'(src_rd), 0);
        chk("mrst_addr", 32'(src_addr), 0);
        chk("mrst_fs", 32'(frame_start), 0);
        chk("mrst_cnt", 32'(frame_cnt), 0);
        exp_cnt = 16'd0;
        cur_g = 2'b00;
        src_req = 2'b11;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mrst_discard", 32'(tape_rgb), 0);
        send(16'd3, 24'h0);
        boundary(2'b01);
        send(16'd3, expv(cur_g, 16'd3));

`ifdef LED_SCHED_BRIGHTNESS_EN
        mem0[2] = 24'hA5B631;
        brightness = 8'h7F;
        send(16'd2, 24'h525B18);
        repeat (2) @(negedge clk);
        brightness = 8'hFF;
        send(16'd2, 24'hA5B631);
`endif

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) chk("sb_drain", 32'(sb.size()), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
